// File: rtl/segdisp_ctrl.sv
// -----------------------------------------------------------------------------
// segdisp_ctrl
//
// Four-digit multiplexed seven-segment display controller with a small CPU
// register file. A free-running prescaler produces a scan step every PRESCALE
// clocks. Each step moves the display to the next digit slot. Segment and digit
// outputs are registered and change only at slot boundaries.
//
// Optional feature macro: SEGDISP_BRIGHTNESS_EN
//   When defined, each slot is split into 8 PWM sub-phases of PRESCALE clocks.
//   The digit enable is driven only while the sub-phase is <= BRIGHT.
//   BRIGHT is then read/write at address 6.
//   When undefined, address 6 reads 0 and writes to it are ignored.
//
// Register map (address[2:0]):
//   0..3 DIGn data   4 CTRL {BLANK[3:0],2'b00,RAW,EN}   5 DP mask [3:0]
//   6    BRIGHT[2:0] 7 STATUS {wrap_toggle,5'b0,scan_index[1:0]} (read-only)
//
// Ports:
//   clk      single clock, rising edge
//   rst      asynchronous active-low reset
//   address  CPU address, only [2:0] decoded
//   cs       register select, active high
//   read     1 = read, 0 = write
//   wdata    write data
//   rdata    registered read data (1-cycle latency, holds while idle)
//   seg      active-low segments, seg[6:0] = g..a, seg[7] = decimal point
//   dig      one-hot active-high digit enables, dig[0] = leftmost digit
// -----------------------------------------------------------------------------
module segdisp_ctrl #(
    parameter int unsigned PRESCALE = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] address,
    input  logic       cs,
    input  logic       read,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] seg,
    output logic [3:0] dig
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr_en;
    logic rd_en;

    assign wr_en = cs & ~read;
    assign rd_en = cs & read;

    // Only the low three address bits are decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[7:3];

    // ------------------------------------------------------------------
    // Digit data registers
    // ------------------------------------------------------------------
    logic [3:0][7:0] digit_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [7:0] data_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    data_reg <= '0;
                end else if (wr_en && (address[2:0] == 3'(gi))) begin
                    data_reg <= wdata;
                end
            end

            assign digit_data[gi] = data_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    logic [7:0] ctrl_reg;      // bits 3:2 are never stored, so they read 0
    logic [3:0] dp_reg;
`ifdef SEGDISP_BRIGHTNESS_EN
    logic [2:0] bright_reg;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_reg   <= 8'h01;
            dp_reg     <= 4'h0;
`ifdef SEGDISP_BRIGHTNESS_EN
            bright_reg <= 3'd7;
`endif
        end else if (wr_en) begin
            case (address[2:0])
                3'd4:    ctrl_reg   <= wdata & 8'hF3;
                3'd5:    dp_reg     <= wdata[3:0];
`ifdef SEGDISP_BRIGHTNESS_EN
                3'd6:    bright_reg <= wdata[2:0];
`endif
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [15:0] presc_reg;
    logic [1:0]  idx_reg;
    logic        wrap_tgl_reg;
    logic [7:0]  seg_reg;
    logic [3:0]  dig_reg;
    logic        step;

    assign step = (presc_reg == PRESC_LAST);

    // ------------------------------------------------------------------
    // Segment pattern for the slot about to be entered (idx_reg)
    // ------------------------------------------------------------------
    logic [7:0] cur_data;
    logic       slot_blank;
    logic [6:0] hex_glyph;
    logic [7:0] cur_seg;
    logic [3:0] cur_dig;

    always_comb begin
        cur_data   = digit_data[idx_reg];
        slot_blank = ~ctrl_reg[0] | ctrl_reg[3'd4 + 3'(idx_reg)];

        // Active-low glyphs, bit order g..a; b and d are lowercase.
        case (cur_data[3:0])
            4'h0:    hex_glyph = 7'h40;
            4'h1:    hex_glyph = 7'h79;
            4'h2:    hex_glyph = 7'h24;
            4'h3:    hex_glyph = 7'h30;
            4'h4:    hex_glyph = 7'h19;
            4'h5:    hex_glyph = 7'h12;
            4'h6:    hex_glyph = 7'h02;
            4'h7:    hex_glyph = 7'h78;
            4'h8:    hex_glyph = 7'h00;
            4'h9:    hex_glyph = 7'h10;
            4'hA:    hex_glyph = 7'h08;
            4'hB:    hex_glyph = 7'h03;
            4'hC:    hex_glyph = 7'h46;
            4'hD:    hex_glyph = 7'h21;
            4'hE:    hex_glyph = 7'h06;
            default: hex_glyph = 7'h0E;
        endcase

        if (slot_blank) begin
            cur_seg = 8'hFF;
            cur_dig = 4'b0000;
        end else begin
            cur_seg = {~dp_reg[idx_reg], (ctrl_reg[1] ? ~cur_data[6:0] : hex_glyph)};
            cur_dig = 4'b0001 << idx_reg;
        end
    end

`ifdef SEGDISP_BRIGHTNESS_EN
    // The sub-counter resets to 7 so that the very first prescaler wrap after
    // reset enters slot 0 at sub-phase 0, just as the plain build does.
    logic [2:0] sub_reg;
    logic [3:0] slot_dig_reg;   // digit enable latched at slot entry

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg    <= '0;
            sub_reg      <= 3'd7;
            idx_reg      <= 2'd0;
            wrap_tgl_reg <= 1'b0;
            slot_dig_reg <= 4'b0000;
            seg_reg      <= 8'hFF;
            dig_reg      <= 4'b0000;
        end else begin
            presc_reg <= step ? 16'd0 : presc_reg + 16'd1;
            if (step) begin
                sub_reg <= sub_reg + 3'd1;
                if (sub_reg == 3'd7) begin
                    // Slot boundary: segments and blanking are sampled only
                    // here so a write never changes a digit mid-slot.
                    seg_reg      <= cur_seg;
                    slot_dig_reg <= cur_dig;
                    dig_reg      <= cur_dig;   // sub-phase 0 is always lit
                    idx_reg      <= idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        wrap_tgl_reg <= ~wrap_tgl_reg;
                    end
                end else begin
                    dig_reg <= ((sub_reg + 3'd1) <= bright_reg) ? slot_dig_reg : 4'b0000;
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg    <= '0;
            idx_reg      <= 2'd0;
            wrap_tgl_reg <= 1'b0;
            seg_reg      <= 8'hFF;
            dig_reg      <= 4'b0000;
        end else begin
            presc_reg <= step ? 16'd0 : presc_reg + 16'd1;
            if (step) begin
                seg_reg <= cur_seg;
                dig_reg <= cur_dig;
                idx_reg <= idx_reg + 2'd1;
                if (idx_reg == 2'd3) begin
                    wrap_tgl_reg <= ~wrap_tgl_reg;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [7:0] rd_mux;
    logic [7:0] rdata_reg;

    always_comb begin
        rd_mux = 8'h00;
        case (address[2:0])
            3'd0, 3'd1, 3'd2, 3'd3: rd_mux = digit_data[address[1:0]];
            3'd4:    rd_mux = ctrl_reg;
            3'd5:    rd_mux = {4'h0, dp_reg};
`ifdef SEGDISP_BRIGHTNESS_EN
            3'd6:    rd_mux = {5'd0, bright_reg};
`else
            3'd6:    rd_mux = 8'h00;
`endif
            default: rd_mux = {wrap_tgl_reg, 5'd0, idx_reg};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_reg <= 8'h00;
        end else if (rd_en) begin
            rdata_reg <= rd_mux;
        end
    end

    assign rdata = rdata_reg;
    assign seg   = seg_reg;
    assign dig   = dig_reg;

endmodule

// File: tb/tb_segdisp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_segdisp_ctrl
//
// Self-checking bench for segdisp_ctrl (default build, PRESCALE = 4).
// A reference model works from clock counts: every P-th clock after reset
// release is a scan step, the k-th step shows digit (k-1) mod 4, and the
// expected display is computed from the model's copy of the register file.
// -----------------------------------------------------------------------------
module tb_segdisp_ctrl;

    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] address = 8'h00;
    logic       cs = 1'b0;
    logic       read = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic [7:0] seg;
    logic [3:0] dig;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    segdisp_ctrl #(.PRESCALE(P)) dut (
        .clk     (clk),
        .rst     (rst_n),
        .address (address),
        .cs      (cs),
        .read    (read),
        .wdata   (wdata),
        .rdata   (rdata),
        .seg     (seg),
        .dig     (dig)
    );

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    // Active-high glyphs (a = bit0); the display is active-low.
    logic [6:0] glyph_on [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic [7:0] m_digit [4];
    logic [7:0] m_ctrl;
    logic [3:0] m_dp;
    int         m_edges;
    int         m_steps;
    logic [7:0] m_seg;
    logic [3:0] m_dig;
    logic [7:0] m_rdata;

    function automatic logic [11:0] slot_view(int s);
        logic [7:0] d;
        d = m_digit[s];
        if (!m_ctrl[0] || m_ctrl[4 + s]) return {4'b0000, 8'hFF};
        return {4'(1 << s), ~m_dp[s], (m_ctrl[1] ? ~d[6:0] : ~glyph_on[d[3:0]])};
    endfunction

    function automatic logic [7:0] reg_view(logic [2:0] a);
        if (a < 3'd4) return m_digit[a[1:0]];
        if (a == 3'd4) return m_ctrl & 8'hF3;
        if (a == 3'd5) return {4'h0, m_dp};
        if (a == 3'd6) return 8'h00;
        return {1'((m_steps / 4) % 2), 5'd0, 2'(m_steps % 4)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_digit[i] <= 8'h00;
            m_ctrl  <= 8'h01;
            m_dp    <= 4'h0;
            m_edges <= 0;
            m_steps <= 0;
            m_seg   <= 8'hFF;
            m_dig   <= 4'b0000;
            m_rdata <= 8'h00;
        end else begin
            m_edges <= m_edges + 1;
            if ((m_edges % P) == (P - 1)) begin
                {m_dig, m_seg} <= slot_view(m_steps % 4);
                m_steps <= m_steps + 1;
            end
            if (cs && read) m_rdata <= reg_view(address[2:0]);
            if (cs && !read) begin
                case (address[2:0])
                    3'd0, 3'd1, 3'd2, 3'd3: m_digit[address[1:0]] <= wdata;
                    3'd4:    m_ctrl <= wdata;
                    3'd5:    m_dp   <= wdata[3:0];
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus stimulus (called at a negedge, returns at the next negedge)
    // ------------------------------------------------------------------
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        address = a; wdata = d; read = 1'b0; cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        $display("WR addr=%0d data=%02h", a, d);
    endtask

    task automatic bus_read(input logic [7:0] a);
        address = a; read = 1'b1; cs = 1'b1;
        @(negedge clk);
        cs = 1'b0; read = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [3:0] want_dig;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (seg !== 8'hFF || dig !== 4'b0000 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_values: seg=%02h dig=%b rdata=%02h required seg=ff dig=0000 rdata=00",
                     seg, dig, rdata);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_checks++;
            if (seg !== m_seg || dig !== m_dig) begin
                n_fail++;
                $display("FAIL reset_scan cycle %0d: seg=%02h dig=%b required seg=%02h dig=%b",
                         k, seg, dig, m_seg, m_dig);
            end
            if (k % P == 0) begin
                want_dig = 4'(1 << (((k / P) - 1) % 4));
                n_checks++;
                if (dig !== want_dig) begin
                    n_fail++;
                    $display("FAIL reset_rotation cycle %0d: dig=%b required %b", k, dig, want_dig);
                end
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_decode();
        logic [7:0] want [4];
        want[0] = 8'h40; want[1] = 8'h92; want[2] = 8'h88; want[3] = 8'h8E;
        bus_write(8'd0, 8'h00);
        bus_write(8'd1, 8'h05);
        bus_write(8'd2, 8'h0A);
        bus_write(8'd3, 8'h0F);
        bus_write(8'd5, 8'h01);
        repeat (2 * P) @(negedge clk);
        for (int k = 0; k < 4 * P; k++) begin
            @(negedge clk);
            n_checks++;
            if (seg !== m_seg || dig !== m_dig) begin
                n_fail++;
                $display("FAIL decode_model: seg=%02h dig=%b required seg=%02h dig=%b", seg, dig, m_seg, m_dig);
            end
            for (int s = 0; s < 4; s++) begin
                if (m_dig == 4'(1 << s)) begin
                    n_checks++;
                    if (seg !== want[s]) begin
                        n_fail++;
                        $display("FAIL decode_slot%0d: seg=%02h required %02h", s, seg, want[s]);
                    end
                end
            end
        end
        $display("test_decode done");
    endtask

    task automatic test_raw_blank();
        logic       seen_slot1;
        logic [3:0] idx_seen;
        bus_write(8'd1, 8'h7F);
        bus_write(8'd4, 8'h03);
        repeat (P) @(negedge clk);
        for (int k = 0; k < 4 * P; k++) begin
            @(negedge clk);
            if (m_dig == 4'b0010) begin
                n_checks++;
                if (seg !== 8'h80) begin
                    n_fail++;
                    $display("FAIL raw_slot1: seg=%02h required 80", seg);
                end
            end
        end
        bus_write(8'd4, 8'h23);
        repeat (P) @(negedge clk);
        seen_slot1 = 1'b0;
        for (int k = 0; k < 4 * P; k++) begin
            @(negedge clk);
            if (dig === 4'b0010) seen_slot1 = 1'b1;
            n_checks++;
            if (seg !== m_seg || dig !== m_dig) begin
                n_fail++;
                $display("FAIL blank_model: seg=%02h dig=%b required seg=%02h dig=%b", seg, dig, m_seg, m_dig);
            end
        end
        n_checks++;
        if (seen_slot1 !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_slot1: dig=0010 observed, required blanked");
        end
        bus_write(8'd4, 8'h00);
        repeat (P) @(negedge clk);
        idx_seen = 4'h0;
        address = 8'd7; read = 1'b1; cs = 1'b1;
        for (int k = 0; k < 4 * P + 1; k++) begin
            @(negedge clk);
            idx_seen[rdata[1:0]] = 1'b1;
            n_checks++;
            if (dig !== 4'b0000 || seg !== 8'hFF || rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL disabled_scan: dig=%b seg=%02h status=%02h required dig=0000 seg=ff status=%02h",
                         dig, seg, rdata, m_rdata);
            end
        end
        cs = 1'b0; read = 1'b0;
        n_checks++;
        if (idx_seen !== 4'hF) begin
            n_fail++;
            $display("FAIL disabled_index_cycles: indices seen %b required 1111", idx_seen);
        end
        bus_write(8'd4, 8'h01);
        $display("test_raw_blank done");
    endtask

    task automatic test_readback();
        int toggles;
        logic prev_b7;
        bus_write(8'd5, 8'hA5);
        bus_read(8'd5);
        n_checks++;
        if (rdata !== 8'h05) begin
            n_fail++;
            $display("FAIL dp_readback: rdata=%02h required 05", rdata);
        end
        address = 8'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (rdata !== 8'h05) begin
            n_fail++;
            $display("FAIL rdata_hold: rdata=%02h required 05", rdata);
        end
        bus_write(8'd4, 8'hFF);
        bus_read(8'd4);
        n_checks++;
        if (rdata !== 8'hF3) begin
            n_fail++;
            $display("FAIL ctrl_readback: rdata=%02h required f3", rdata);
        end
        bus_write(8'd4, 8'h01);
        bus_read(8'd7);
        prev_b7 = rdata[7];
        toggles = 0;
        address = 8'd7; read = 1'b1; cs = 1'b1;
        for (int k = 0; k < 10 * P; k++) begin
            @(negedge clk);
            if (rdata[7] !== prev_b7) toggles++;
            prev_b7 = rdata[7];
            n_checks++;
            if (rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL status_read: rdata=%02h required %02h", rdata, m_rdata);
            end
        end
        cs = 1'b0; read = 1'b0;
        n_checks++;
        if (toggles < 2) begin
            n_fail++;
            $display("FAIL wrap_toggle: %0d toggles in 10 steps, required at least 2", toggles);
        end
        $display("test_readback done");
    endtask

    task automatic test_brightness();
        bus_write(8'd6, 8'hFF);
        bus_read(8'd6);
        n_checks++;
        if (rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL bright_absent: rdata=%02h required 00", rdata);
        end
        bus_write(8'd7, 8'hFF);
        bus_read(8'd7);
        n_checks++;
        if (rdata !== m_rdata || rdata[6:2] !== 5'd0) begin
            n_fail++;
            $display("FAIL status_readonly: rdata=%02h required %02h", rdata, m_rdata);
        end
        $display("test_brightness done");
    endtask

    task automatic test_random();
        logic [2:0] a;
        for (int k = 0; k < 300; k++) begin
            n_checks++;
            if (seg !== m_seg || dig !== m_dig || rdata !== m_rdata) begin
                n_fail++;
                $display("FAIL random cycle %0d: seg=%02h dig=%b rdata=%02h required seg=%02h dig=%b rdata=%02h",
                         k, seg, dig, rdata, m_seg, m_dig, m_rdata);
            end
            a = 3'($urandom_range(0, 7));
            address = {5'($urandom), a};
            wdata   = 8'($urandom);
            cs      = ($urandom_range(0, 3) == 0);
            read    = $urandom_range(0, 1) == 1;
            // keep the display enabled most of the time
            if (cs && !read && a == 3'd4) wdata[0] = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        cs = 1'b0; read = 1'b0;
        $display("test_random done");
    endtask

    task automatic test_midslot_reset();
        logic       found;
        logic [7:0] held_seg;
        bus_write(8'd4, 8'h01);
        found = 1'b0;
        for (int k = 0; k < 10 * P && !found; k++) begin
            @(negedge clk);
            if (m_dig == 4'b0100 && (m_edges % P) == 0) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL midslot_sync: slot 2 start not reached within budget");
        end
        held_seg = m_seg;
        bus_write(8'd2, 8'h3C ^ m_digit[2]);
        for (int k = 0; k < P - 2; k++) begin
            n_checks++;
            if (seg !== held_seg || dig !== 4'b0100) begin
                n_fail++;
                $display("FAIL midslot_hold: seg=%02h dig=%b required seg=%02h dig=0100", seg, dig, held_seg);
            end
            if (k < P - 3) @(negedge clk);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (seg !== 8'hFF || dig !== 4'b0000 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL midslot_reset: seg=%02h dig=%b rdata=%02h required seg=ff dig=0000 rdata=00",
                     seg, dig, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(8'd2);
        n_checks++;
        if (rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL midslot_dig2_cleared: rdata=%02h required 00", rdata);
        end
        bus_read(8'd4);
        n_checks++;
        if (rdata !== 8'h01) begin
            n_fail++;
            $display("FAIL midslot_ctrl_reset: rdata=%02h required 01", rdata);
        end
        for (int k = 0; k < 2 * P; k++) begin
            @(negedge clk);
            n_checks++;
            if (seg !== m_seg || dig !== m_dig) begin
                n_fail++;
                $display("FAIL post_reset_scan: seg=%02h dig=%b required seg=%02h dig=%b", seg, dig, m_seg, m_dig);
            end
        end
        $display("test_midslot_reset done");
    endtask

    initial begin
        test_reset();
        test_decode();
        test_raw_blank();
        test_readback();
        test_brightness();
        test_random();
        test_midslot_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/segdisp_ctrl.md
SEGDISP_CTRL -- requirements
Module: segdisp_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 2000: clk ticks per scan step; legal range 2..65535.
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous active-low reset.
REQ-004 SHALL have port address  in  8  CPU bus address; only address[2:0] is decoded.
REQ-005 SHALL have port cs  in  1  select from the top-level address decode; active high.
REQ-006 SHALL have port read  in  1  CPU direction: 1 = read, 0 = write.
REQ-007 SHALL have port wdata  in  8  write data, driven from CPU dout.
REQ-008 SHALL have port rdata  out  8  registered read data, driven to the CPU din mux.
REQ-009 SHALL have port seg  out  8  segments, active-low; seg[6:0] is g..a and seg[7] is the decimal point.
REQ-010 SHALL have port dig  out  4  digit enables, one-hot, active-high; dig[0] is the leftmost digit.

Function
REQ-011 SHALL provide a register map: 0..3 = DIGn data; 4 = CTRL; 5 = DP mask[3:0]; 6 = BRIGHT[2:0]; 7 = STATUS (read-only).
REQ-012 CTRL SHALL be laid out as: bit0 EN, bit1 RAW, bits7:4 BLANK mask (bit n blanks digit n). Bits 3:2 SHALL read 0.
REQ-013 A write SHALL occur on a clk edge with cs=1 and read=0, and SHALL be visible to the scanner on the next edge. Writes to address 7 SHALL be ignored.
REQ-014 A read with cs=1 and read=1 SHALL load rdata on that edge, giving 1-cycle latency. Unused bits SHALL read 0. rdata SHALL hold its value while cs=0.
REQ-015 STATUS SHALL be laid out as: bits1:0 = current scan index; bit7 = toggles on every wrap from index 3 to 0.
REQ-016 The prescaler SHALL count 0..PRESCALE-1. On terminal count it SHALL wrap to 0 and emit a one-cycle step.
REQ-017 On each step the scan index SHALL advance 0->1->2->3->0.
REQ-018 seg and dig SHALL be registered outputs that update on the edge following a step.
REQ-019 When RAW=0, seg[6:0] SHALL be the hex decode of DIGn[3:0], with 0-F standard glyphs and b and d lowercase. When RAW=1, seg[6:0] = ~DIGn[6:0].
REQ-020 seg[7] SHALL be driven as ~DP[n].
REQ-021 When EN=0 or BLANK[n]=1: dig = 4'b0000 during slot n and seg = 8'hFF. Scanning SHALL continue regardless.
REQ-022 A write to DIGn while n is the active digit SHALL take effect at the next step, never mid-slot.
REQ-023 The prescaler and scan index SHALL be unaffected by bus accesses.

Reset
REQ-024 On rst=0, asynchronously: DIG0..3 = 0, CTRL = 8'h01 (EN=1), DP = 0, BRIGHT = 3'd7, prescaler = 0, scan index = 0, wrap toggle = 0, rdata = 0, seg = 8'hFF, dig = 4'b0000.
REQ-025 The first digit enable SHALL appear one step after rst is released.
REQ-026 Reset asserted mid-slot SHALL abort the slot with no partial state retained.

Configuration
REQ-027 The macro SEGDISP_BRIGHTNESS_EN SHALL compile PWM dimming in or out.
REQ-028 With SEGDISP_BRIGHTNESS_EN defined:
- Each slot SHALL be divided into 8 sub-phases of PRESCALE ticks each, via a 3-bit sub-counter that increments on each prescaler wrap.
- The scan index SHALL advance only when the sub-counter wraps from 7 to 0.
- dig SHALL be asserted only while sub-counter <= BRIGHT.
- BRIGHT SHALL be read/write at address 6.
REQ-029 Without SEGDISP_BRIGHTNESS_EN:
- Each slot SHALL be PRESCALE ticks long.
- dig SHALL be asserted for the whole slot.
- Address 6 SHALL read 0, and writes to it SHALL be ignored.

Verification
REQ-030 Reset test, PRESCALE=4: pulse rst low for 3 cycles, then release. Required: seg=FF and dig=0000 during reset; dig=0001 by cycle 5 after release; dig then rotates 0010, 0100, 1000, 0001 every 4 cycles.
REQ-031 Decode test: write DIG0..3 = 0,5,A,F and DP=4'b0001. Required: seg = 8'h40, 8'h92, 8'h88, 8'h8E in slots 0..3 (slot 0 with DP on).
REQ-032 Raw and blank test: write CTRL=8'h23 and DIG1=8'h7F. Required: slot 1 gives seg=8'h80; slot 1 shows dig=0000 once CTRL=8'h23 is applied with BLANK bit 1 set. Then write CTRL=0: dig stays 0000 while STATUS[1:0] keeps cycling.
REQ-033 Read-back test: write 8'hA5 to address 5, then read it. Required: rdata=8'h05 one cycle later. Read address 7 at wrap and check that bit7 toggles.
REQ-034 Brightness test with SEGDISP_BRIGHTNESS_EN defined: BRIGHT=1, PRESCALE=4. Required: dig high for 8 of 32 ticks per slot. Without the macro: address 6 reads 8'h00.
REQ-035 Mid-slot test: during slot 2, write DIG2, then assert rst. Required: seg is unchanged until the next step. The reset causes an immediate return to the reset values of REQ-024.
